ram_read_cache: RTL and testbench
=================================

# ram_read_cache

Parametrised read-side front end for the DDR3 MIG user interface. It serves word-addressed read requests from a small direct-mapped line cache and issues one MIG burst read per miss. Each burst fills one cache line. Hits return in one cycle without touching the MIG. Sits between display/sample consumers and the MIG app port; it replaces single-line, single-word-width read buffering.

## Interface
- ADDR_W, 27, word address width (MIG app address width)
- WORD_W, 16, returned word width; must divide DATA_W
- DATA_W, 64, MIG read beat width
- BURST_BEATS, 2, beats per MIG read; line = BURST_BEATS*DATA_W bits, WPL = line/WORD_W words (power of 2)
- LINES, 4, cache lines (power of 2, ≥1)
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high
- req_valid  in  1  read request
- req_addr  in  ADDR_W  word address
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  WORD_W  requested word
- flush  in  1  invalidate all lines
- ram_address  out  ADDR_W  MIG command address (line-aligned)
- ram_cmd  out  3  MIG command, 3'b001 = read
- ram_en  out  1  MIG command enable
- ram_rdy  in  1  MIG command accept
- ram_rd_valid  in  1  read beat valid
- ram_rd_data_end  in  1  last beat of burst
- ram_rd_data  in  DATA_W  read beat
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter
- burst_err  out  1  sticky: burst length mismatch

## Operation
- Address split: offset = addr[log2(WPL)-1:0]; index = next log2(LINES) bits; tag = remaining upper bits. Per line: valid bit, tag, line data.
- Line layout: word k at line bits [k*WORD_W +: WORD_W]. Beat i (0-based arrival order) is written to line bits [(BURST_BEATS-1-i)*DATA_W +: DATA_W]. The last beat therefore holds words 0..DATA_W/WORD_W-1.
- FSM states:
  - IDLE: req_ready = !flush. On an accepted request, compare index/tag.
    - Hit: register the word to rsp_data, pulse rsp_valid next cycle, hit_count++, stay in IDLE.
    - Miss: latch the address, miss_count++, go to CMD.
  - CMD: ram_en=1, ram_cmd=3'b001, ram_address = req_addr with offset bits cleared. On the cycle ram_en && ram_rdy, go to FILL and drop ram_en the next cycle.
  - FILL: each ram_rd_valid writes one beat and increments the beat counter. On beat BURST_BEATS: set valid, write tag, go to RESP.
  - RESP: rsp_valid=1 with the requested word from the fresh line, then go to IDLE.
- ram_rd_valid outside FILL is ignored.
- In FILL, if ram_rd_data_end disagrees with the beat count (end early or missing on the last beat), set burst_err. The fill still completes on beat count.
- flush in IDLE: all valid bits clear at that edge, and no request is accepted that cycle.
- flush in CMD/FILL/RESP: latched as pending. The in-flight miss completes and responds, then all lines are invalidated on entering IDLE.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - ram_en=0, ram_cmd=3'b000, ram_address=0
  - rsp_valid=0, rsp_data=0
  - counters=0, burst_err=0, all valid=0, pending flush=0
  - state=IDLE; req_ready=1 after reset releases if flush=0
- Reset mid-operation aborts the command or fill immediately. Beats arriving after reset are ignored (state IDLE).
- Hit latency: request accepted at edge N, rsp_valid high in cycle N+1. Back-to-back hits sustain one response per cycle.
- Miss latency: one cycle to CMD, plus ram_rdy wait, plus MIG read latency, plus one RESP cycle. req_ready=0 from CMD through RESP.
- ram_address and ram_cmd stay stable while ram_en=1 and ram_rdy=0.

## Test plan
- Cold miss: req 0x0000013 → ram_address 0x0000010, ram_cmd 001, ram_en until ram_rdy. Beats 64'h0007_0006_0005_0004 then (end) 64'h0003_0002_0001_0000 → rsp_data 16'h0003, miss_count 1.
- Hit: next req 0x0000015 → rsp_valid cycle after accept, rsp_data 16'h0005, no ram_en, hit_count 1. Four consecutive hits → four consecutive rsp_valid.
- Conflict: req 0x0000033 (same index 2, different tag) → miss, refill. Then 0x0000013 → miss again.
- Back-pressure: ram_rdy low 5 cycles in CMD → ram_en held high with ram_address constant. Exactly one command is accepted.
- Flush: flush during FILL → pending request still returns correct data. Then req 0x0000033 → miss. Early ram_rd_data_end on beat 0 → burst_err=1 and stays 1.
- Reset mid-FILL after one beat → all outputs at reset values. Stray beat ignored. Req 0x0000013 → miss.

Source files
------------

// File: rtl/ram_read_cache.sv
// Direct-mapped read cache in front of the DDR3 MIG app port. Hits answer in one cycle;
// each miss issues one line-aligned burst read and fills one line.
module ram_read_cache #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_BEATS = 2,
  parameter int unsigned LINES       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] ram_address,
  output logic [2:0]        ram_cmd,
  output logic              ram_en,
  input  logic              ram_rdy,
  input  logic              ram_rd_valid,
  input  logic              ram_rd_data_end,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic              burst_err
);

  localparam int unsigned LINE_W   = BURST_BEATS * DATA_W;
  localparam int unsigned WPL      = LINE_W / WORD_W;
  localparam int unsigned OFF_W    = $clog2(WPL);
  localparam int unsigned IDX_BITS = $clog2(LINES);
  // Keep a legal vector width when there is a single line.
  localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int unsigned TAG_W    = ADDR_W - OFF_W - IDX_BITS;
  localparam int unsigned BEAT_W   = $clog2(BURST_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StFill, StResp} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   tag_d [LINES];
  logic [LINE_W-1:0]  data_q [LINES];
  logic [LINE_W-1:0]  data_d [LINES];
  logic               rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]  rsp_data_q, rsp_data_d;
  logic [31:0]        hit_q, hit_d, miss_q, miss_d;
  logic               err_q, err_d;
  logic               flush_pend_q, flush_pend_d;

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic               req_hit, last_beat;
  logic [LINE_W-1:0]  fill_line;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    if (IDX_BITS == 0) return '0;
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [ADDR_W-1:0] a);
    return line[int'(a[OFF_W-1:0]) * WORD_W +: WORD_W];
  endfunction

  assign req_ready   = (state_q == StIdle) && !flush;
  assign ram_en      = (state_q == StCmd);
  assign ram_cmd     = ram_en ? 3'b001 : 3'b000;
  assign ram_address = ram_en ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign burst_err   = err_q;

  // Lookup, line fill assembly and next-state for the FSM and all bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;

    req_idx   = idx_of(req_addr);
    req_hit   = valid_q[req_idx] && (tag_q[req_idx] == tag_of(req_addr));
    fill_idx  = idx_of(addr_q);
    last_beat = (beat_q == BEAT_W'(BURST_BEATS - 1));
    // First-arriving beat lands in the most significant slot of the line.
    fill_line = data_q[fill_idx];
    fill_line[(BURST_BEATS - 1 - int'(beat_q)) * DATA_W +: DATA_W] = ram_rd_data;

    if (flush && (state_q == StCmd || state_q == StFill)) flush_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (flush) begin
          valid_d = '0;
        end else if (req_valid) begin
          if (req_hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = word_of(data_q[req_idx], req_addr);
            if (hit_q != 32'hFFFF_FFFF) hit_d = hit_q + 32'd1;
          end else begin
            addr_d  = req_addr;
            beat_d  = '0;
            state_d = StCmd;
            if (miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
          end
        end
      end
      StCmd: begin
        if (ram_rdy) state_d = StFill;
      end
      StFill: begin
        if (ram_rd_valid) begin
          data_d[fill_idx] = fill_line;
          beat_d           = beat_q + BEAT_W'(1);
          if (ram_rd_data_end != last_beat) err_d = 1'b1;
          if (last_beat) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = tag_of(addr_q);
            rsp_valid_d       = 1'b1;
            rsp_data_d        = word_of(fill_line, addr_q);
            state_d           = StResp;
          end
        end
      end
      StResp: begin
        state_d      = StIdle;
        flush_pend_d = 1'b0;
        if (flush_pend_q || flush) valid_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and storage registers; reset abandons any in-flight command or fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_q       <= '0;
      valid_q      <= '0;
      tag_q        <= '{default: '0};
      data_q       <= '{default: '0};
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_ram_read_cache.sv
// Directed bench for ram_read_cache: a table of requests plus hand-written multi-cycle
// sequences for back-to-back hits, flush, and reset during a fill.
module tb_ram_read_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [26:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        flush;
  logic [26:0] ram_address;
  logic [2:0]  ram_cmd;
  logic        ram_en;
  logic        ram_rdy;
  logic        ram_rd_valid;
  logic        ram_rd_data_end;
  logic [63:0] ram_rd_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        burst_err;

  ram_read_cache dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .flush           (flush),
    .ram_address     (ram_address),
    .ram_cmd         (ram_cmd),
    .ram_en          (ram_en),
    .ram_rdy         (ram_rdy),
    .ram_rd_valid    (ram_rd_valid),
    .ram_rd_data_end (ram_rd_data_end),
    .ram_rd_data     (ram_rd_data),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .burst_err       (burst_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  bit exp_err = 1'b0;
  int cmd_cnt = 0;

  // Count accepted MIG commands so duplicate issues are visible.
  always @(posedge clk) if (ram_en && ram_rdy) cmd_cnt <= cmd_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory model: word value is the low 16 address bits with bit 4 inverted.
  function automatic logic [15:0] mem_word(input logic [26:0] a);
    return a[15:0] ^ 16'h0010;
  endfunction

  // Beat i carries words (1-i)*4 .. (1-i)*4+3 of the 8-word line.
  function automatic logic [63:0] beat(input logic [26:0] base, input int i);
    logic [63:0] b;
    for (int w = 0; w < 4; w++) b[w*16 +: 16] = mem_word(base + 27'((1 - i) * 4 + w));
    return b;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, " hit_count"}, 64'(hit_count), 64'(exp_hits));
    chk({tag, " miss_count"}, 64'(miss_count), 64'(exp_misses));
    chk({tag, " burst_err"}, 64'(burst_err), 64'(exp_err));
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE (or just after a hit).
  task automatic do_req(input logic [26:0] a, input bit hit, input logic [15:0] d,
                        input int dly, input bit early);
    logic [26:0] base;
    int          cmds0;
    base  = a & ~27'h7;
    cmds0 = cmd_cnt;
    req_valid = 1'b1;
    req_addr  = a;
    #1 chk("req_ready idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (hit) begin
      exp_hits++;
      chk("hit rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hit rsp_data", 64'(rsp_data), 64'(d));
      chk("hit ram_en", 64'(ram_en), 64'd0);
    end else begin
      exp_misses++;
      chk("cmd ram_en", 64'(ram_en), 64'd1);
      chk("cmd ram_cmd", 64'(ram_cmd), 64'd1);
      chk("cmd ram_address", 64'(ram_address), 64'(base));
      chk("cmd req_ready", 64'(req_ready), 64'd0);
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        chk("stall ram_en", 64'(ram_en), 64'd1);
        chk("stall ram_address", 64'(ram_address), 64'(base));
      end
      ram_rdy = 1'b1;
      @(negedge clk);
      ram_rdy = 1'b0;
      chk("fill ram_en dropped", 64'(ram_en), 64'd0);
      for (int i = 0; i < 2; i++) begin
        ram_rd_valid    = 1'b1;
        ram_rd_data     = beat(base, i);
        ram_rd_data_end = early ? (i == 0) : (i == 1);
        @(negedge clk);
      end
      ram_rd_valid    = 1'b0;
      ram_rd_data_end = 1'b0;
      if (early) exp_err = 1'b1;
      chk("resp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("resp rsp_data", 64'(rsp_data), 64'(d));
      chk("resp req_ready", 64'(req_ready), 64'd0);
      chk("one command", 64'(cmd_cnt - cmds0), 64'd1);
      @(negedge clk);
      chk("after resp rsp_valid", 64'(rsp_valid), 64'd0);
    end
    chk_counters("req");
  endtask

  typedef struct {
    logic [26:0] addr;
    bit          hit;
    logic [15:0] data;
    int          dly;
    bit          early;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{27'h0000013, 1'b0, 16'h0003, 0, 1'b0}; // cold miss
    vecs[1] = '{27'h0000015, 1'b1, 16'h0005, 0, 1'b0}; // hit same line
    vecs[2] = '{27'h0000033, 1'b0, 16'h0023, 5, 1'b0}; // conflict, ram_rdy held low
    vecs[3] = '{27'h0000015, 1'b0, 16'h0005, 0, 1'b0}; // evicted line misses again
    vecs[4] = '{27'h0000008, 1'b0, 16'h0018, 2, 1'b0}; // index 1
    vecs[5] = '{27'h000000F, 1'b1, 16'h001F, 0, 1'b0};
    vecs[6] = '{27'h7FFFFF3, 1'b0, 16'hFFE3, 1, 1'b0}; // top tag bits
    vecs[7] = '{27'h0000013, 1'b0, 16'h0003, 0, 1'b1}; // early data_end
    vecs[8] = '{27'h000000A, 1'b1, 16'h001A, 0, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    ram_rdy = 1'b0;
    ram_rd_valid = 1'b0;
    ram_rd_data_end = 1'b0;
    ram_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst ram_en", 64'(ram_en), 64'd0);
    chk("rst ram_cmd", 64'(ram_cmd), 64'd0);
    chk("rst ram_address", 64'(ram_address), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk_counters("rst");

    foreach (vecs[i]) do_req(vecs[i].addr, vecs[i].hit, vecs[i].data, vecs[i].dly, vecs[i].early);

    // Four back-to-back hits on line 0x10.
    begin
      logic [26:0] ha [4];
      logic [15:0] hd [4];
      ha = '{27'h10, 27'h11, 27'h16, 27'h17};
      hd = '{16'h0000, 16'h0001, 16'h0006, 16'h0007};
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        req_addr = ha[i];
        @(negedge clk);
        exp_hits++;
        chk("b2b rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b rsp_data", 64'(rsp_data), 64'(hd[i]));
        chk("b2b ram_en", 64'(ram_en), 64'd0);
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk_counters("b2b");
    end

    // Flush raised during FILL: the pending miss still answers, then everything is invalid.
    req_valid = 1'b1;
    req_addr  = 27'h33;
    @(negedge clk);
    req_valid = 1'b0;
    exp_misses++;
    chk("fl cmd ram_address", 64'(ram_address), 64'h30);
    ram_rdy = 1'b1;
    @(negedge clk);
    ram_rdy = 1'b0;
    flush = 1'b1;
    ram_rd_valid = 1'b1;
    ram_rd_data = beat(27'h30, 0);
    ram_rd_data_end = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    ram_rd_data = beat(27'h30, 1);
    ram_rd_data_end = 1'b1;
    @(negedge clk);
    ram_rd_valid = 1'b0;
    ram_rd_data_end = 1'b0;
    chk("fl rsp_valid", 64'(rsp_valid), 64'd1);
    chk("fl rsp_data", 64'(rsp_data), 64'h0023);
    @(negedge clk);
    do_req(27'h33, 1'b0, 16'h0023, 0, 1'b0);
    do_req(27'h08, 1'b0, 16'h0018, 0, 1'b0);

    // Flush in IDLE blocks the request that cycle and clears all lines.
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 27'h08;
    #1 chk("flush req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush no rsp", 64'(rsp_valid), 64'd0);
    chk("flush no cmd", 64'(ram_en), 64'd0);
    do_req(27'h08, 1'b0, 16'h0018, 0, 1'b0);

    // Reset after one beat of a fill.
    req_valid = 1'b1;
    req_addr = 27'h13;
    @(negedge clk);
    req_valid = 1'b0;
    ram_rdy = 1'b1;
    @(negedge clk);
    ram_rdy = 1'b0;
    ram_rd_valid = 1'b1;
    ram_rd_data = beat(27'h10, 0);
    @(negedge clk);
    ram_rd_valid = 1'b0;
    reset = 1'b1;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    exp_err = 1'b0;
    chk("mid rst ram_en", 64'(ram_en), 64'd0);
    chk("mid rst ram_cmd", 64'(ram_cmd), 64'd0);
    chk("mid rst ram_address", 64'(ram_address), 64'd0);
    chk("mid rst rsp_data", 64'(rsp_data), 64'd0);
    chk_counters("mid rst");
    @(negedge clk);
    reset = 1'b0;
    ram_rd_valid = 1'b1;
    ram_rd_data = beat(27'h10, 1);
    ram_rd_data_end = 1'b1;
    @(negedge clk);
    ram_rd_valid = 1'b0;
    ram_rd_data_end = 1'b0;
    chk("stray rsp_valid", 64'(rsp_valid), 64'd0);
    chk("stray ram_en", 64'(ram_en), 64'd0);
    chk("stray req_ready", 64'(req_ready), 64'd1);
    do_req(27'h13, 1'b0, 16'h0003, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
